// File: rtl/bip_control_unit_if.sv
// ---------------------------------------------------------------------------
// bip_control_unit_if
// Bundles the signals between the BIP control unit and its surroundings
// (program memory, program counter, accumulator/ALU datapath, data memory).
//   instruction  : program memory word at the current PC
//   WrPC         : program counter increment pulse
//   SelA / SelB  : accumulator input select / ALU operand B select
//   WrAcc        : accumulator write enable
//   Op           : ALU operation (100000 add, 100010 sub, 000000 idle)
//   WrRam / RdRam: data memory write / read strobes
//   operand      : IR operand field (address or immediate)
//   halted       : high once HLT has executed
//   clk_count    : cycles since reset up to and including the halt cycle
//   instr_count  : retired (WrPC) instructions since reset
// modport master : the control unit (drives controls, reads instruction)
// modport slave  : the environment (drives instruction, reads controls)
// ---------------------------------------------------------------------------
interface bip_control_unit_if #(
    parameter int bits_address = 11,
    parameter int bits_opcode  = 5,
    parameter int bits_count   = 16
);
    logic [bits_opcode+bits_address-1:0] instruction;
    logic                                WrPC;
    logic [1:0]                          SelA;
    logic                                SelB;
    logic                                WrAcc;
    logic [5:0]                          Op;
    logic                                WrRam;
    logic                                RdRam;
    logic [bits_address-1:0]             operand;
    logic                                halted;
    logic [bits_count-1:0]               clk_count;
    logic [bits_count-1:0]               instr_count;

    modport master (
        input  instruction,
        output WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, operand,
        output halted, clk_count, instr_count
    );

    modport slave (
        output instruction,
        input  WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, operand,
        input  halted, clk_count, instr_count
    );
endinterface

// File: rtl/bip_control_unit.sv
// ---------------------------------------------------------------------------
// bip_control_unit
// Multi-cycle FETCH / DECODE / MEM / HALT controller for the BIP processor.
// Captures the program memory word into the IR, decodes it and drives the
// datapath strobes, and keeps saturating cycle / retired-instruction counters.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : bip_control_unit_if.master (instruction in, controls/counters out)
// All controls are registered: the values shown in a state are computed on
// the edge that enters it, so an asynchronous reset clears them immediately.
// ---------------------------------------------------------------------------
module bip_control_unit #(
    parameter int bits_address = 11,
    parameter int bits_opcode  = 5,
    parameter int bits_count   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bip_control_unit_if.master    bus
);
    typedef enum logic [1:0] {FETCH, DECODE, MEM, HALT} state_t;

    localparam logic [bits_opcode-1:0] OPC_HLT  = bits_opcode'(0);
    localparam logic [bits_opcode-1:0] OPC_STO  = bits_opcode'(1);
    localparam logic [bits_opcode-1:0] OPC_LD   = bits_opcode'(2);
    localparam logic [bits_opcode-1:0] OPC_LDI  = bits_opcode'(3);
    localparam logic [bits_opcode-1:0] OPC_ADD  = bits_opcode'(4);
    localparam logic [bits_opcode-1:0] OPC_ADDI = bits_opcode'(5);
    localparam logic [bits_opcode-1:0] OPC_SUB  = bits_opcode'(6);
    localparam logic [bits_opcode-1:0] OPC_SUBI = bits_opcode'(7);

    localparam logic [5:0] ALU_NONE = 6'b000000;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;

    localparam int IR_W = bits_opcode + bits_address;

    state_t                 state_q;
    logic [IR_W-1:0]        ir_q;
    logic                   wrpc_q;
    logic [1:0]             sela_q;
    logic                   selb_q;
    logic                   wracc_q;
    logic [5:0]             op_q;
    logic                   wrram_q;
    logic                   rdram_q;
    logic                   halted_q;
    logic [bits_count-1:0]  clk_count_q, clk_count_d;
    logic [bits_count-1:0]  instr_count_q, instr_count_d;

    logic [bits_opcode-1:0] fetch_opc;
    logic [bits_opcode-1:0] ir_opc;

    assign fetch_opc = bus.instruction[IR_W-1 -: bits_opcode];
    assign ir_opc    = ir_q[IR_W-1 -: bits_opcode];

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [bits_count-1:0] sat_inc(input logic [bits_count-1:0] v);
        return (&v) ? v : v + bits_count'(1);
    endfunction

    always_comb begin
        clk_count_d   = (state_q != HALT) ? sat_inc(clk_count_q) : clk_count_q;
        instr_count_d = wrpc_q ? sat_inc(instr_count_q) : instr_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            ir_q          <= '0;
            wrpc_q        <= 1'b0;
            sela_q        <= 2'b00;
            selb_q        <= 1'b0;
            wracc_q       <= 1'b0;
            op_q          <= ALU_NONE;
            wrram_q       <= 1'b0;
            rdram_q       <= 1'b0;
            halted_q      <= 1'b0;
            clk_count_q   <= '0;
            instr_count_q <= '0;
        end else begin
            clk_count_q   <= clk_count_d;
            instr_count_q <= instr_count_d;

            // Strobes are single-cycle unless the next state sets them again.
            wrpc_q  <= 1'b0;
            sela_q  <= 2'b00;
            selb_q  <= 1'b0;
            wracc_q <= 1'b0;
            op_q    <= ALU_NONE;
            wrram_q <= 1'b0;
            rdram_q <= 1'b0;

            case (state_q)
                FETCH: begin
                    ir_q    <= bus.instruction;
                    state_q <= DECODE;
                    // Decode straight from the incoming word so the DECODE
                    // cycle already presents its controls.
                    case (fetch_opc)
                        OPC_HLT: ;
                        OPC_STO: begin
                            wrram_q <= 1'b1;
                            wrpc_q  <= 1'b1;
                        end
                        OPC_LD, OPC_ADD, OPC_SUB: begin
                            rdram_q <= 1'b1;
                        end
                        OPC_LDI: begin
                            sela_q  <= 2'b01;
                            wracc_q <= 1'b1;
                            wrpc_q  <= 1'b1;
                        end
                        OPC_ADDI, OPC_SUBI: begin
                            sela_q  <= 2'b10;
                            selb_q  <= 1'b1;
                            op_q    <= (fetch_opc == OPC_ADDI) ? ALU_ADD : ALU_SUB;
                            wracc_q <= 1'b1;
                            wrpc_q  <= 1'b1;
                        end
                        default: begin
                            wrpc_q <= 1'b1;
                        end
                    endcase
                end
                DECODE: begin
                    case (ir_opc)
                        OPC_HLT: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                        OPC_LD, OPC_ADD, OPC_SUB: begin
                            // Memory operand arrives now; consume it in MEM.
                            state_q <= MEM;
                            rdram_q <= 1'b1;
                            wracc_q <= 1'b1;
                            wrpc_q  <= 1'b1;
                            if (ir_opc != OPC_LD) begin
                                sela_q <= 2'b10;
                                op_q   <= (ir_opc == OPC_ADD) ? ALU_ADD : ALU_SUB;
                            end
                        end
                        default: begin
                            state_q <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    state_q <= FETCH;
                end
                HALT: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    assign bus.WrPC        = wrpc_q;
    assign bus.SelA        = sela_q;
    assign bus.SelB        = selb_q;
    assign bus.WrAcc       = wracc_q;
    assign bus.Op          = op_q;
    assign bus.WrRam       = wrram_q;
    assign bus.RdRam       = rdram_q;
    assign bus.operand     = ir_q[bits_address-1:0];
    assign bus.halted      = halted_q;
    assign bus.clk_count   = clk_count_q;
    assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_bip_control_unit.sv
module tb_bip_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic rst4  = 1'b1;

    bip_control_unit_if #(.bits_address(11), .bits_opcode(5), .bits_count(16)) bus ();
    bip_control_unit_if #(.bits_address(11), .bits_opcode(5), .bits_count(4))  bus4 ();

    bip_control_unit #(.bits_address(11), .bits_opcode(5), .bits_count(16)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    bip_control_unit #(.bits_address(11), .bits_opcode(5), .bits_count(4)) dut4 (
        .clk(clk), .reset(rst4), .bus(bus4));

    // Program memory and program counter surrounding the control unit
    logic [15:0] mem [0:2047];
    logic [10:0] pc;
    assign bus.instruction  = mem[pc];
    assign bus4.instruction = 16'hF800;

    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 11'd0;
        else if (bus.WrPC) pc <= pc + 11'd1;
    end

    typedef struct {
        logic        wrpc;
        logic [1:0]  sela;
        logic        selb;
        logic        wracc;
        logic [5:0]  op;
        logic        wrram;
        logic        rdram;
        logic [10:0] opnd;
        logic        hlt;
        logic [15:0] cc;
        logic [15:0] ic;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [15:0] pq[$];
    int          checks = 0;
    int          failures = 0;
    int          m_cc, m_ic;
    logic [10:0] m_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: one entry per clock cycle of observable behaviour.
    task automatic push(input logic wrpc, input logic [1:0] sela, input logic selb,
                        input logic wracc, input logic [5:0] op, input logic wrram,
                        input logic rdram, input logic hlt);
        exp_t x;
        x.wrpc = wrpc; x.sela = sela; x.selb = selb; x.wracc = wracc; x.op = op;
        x.wrram = wrram; x.rdram = rdram; x.opnd = m_ir; x.hlt = hlt;
        x.cc = 16'(m_cc); x.ic = 16'(m_ic);
        exp_q.push_back(x);
        if (!hlt && m_cc < 65535) m_cc++;
        if (wrpc && m_ic < 65535) m_ic++;
    endtask

    task automatic expand(input logic [15:0] w);
        push(0, 2'b00, 0, 0, 6'd0, 0, 0, 0);      // fetch cycle
        m_ir = w[10:0];
        case (w[15:11])
            5'd0: push(0, 2'b00, 0, 0, 6'd0, 0, 0, 0);
            5'd1: push(1, 2'b00, 0, 0, 6'd0, 1, 0, 0);
            5'd2: begin
                push(0, 2'b00, 0, 0, 6'd0, 0, 1, 0);
                push(1, 2'b00, 0, 1, 6'd0, 0, 1, 0);
            end
            5'd3: push(1, 2'b01, 0, 1, 6'd0, 0, 0, 0);
            5'd4: begin
                push(0, 2'b00, 0, 0, 6'd0, 0, 1, 0);
                push(1, 2'b10, 0, 1, 6'b100000, 0, 1, 0);
            end
            5'd5: push(1, 2'b10, 1, 1, 6'b100000, 0, 0, 0);
            5'd6: begin
                push(0, 2'b00, 0, 0, 6'd0, 0, 1, 0);
                push(1, 2'b10, 0, 1, 6'b100010, 0, 1, 0);
            end
            5'd7: push(1, 2'b10, 1, 1, 6'b100010, 0, 0, 0);
            default: push(1, 2'b00, 0, 0, 6'd0, 0, 0, 0);
        endcase
    endtask

    // Runs pq (terminated by HLT) from reset, then holds in HALT.
    task automatic run_prog(input int hold);
        reset = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        for (int i = 0; i < pq.size(); i++) mem[i] = pq[i];
        m_cc = 0; m_ic = 0; m_ir = 11'd0;
        exp_q.delete();
        for (int i = 0; i < pq.size(); i++) expand(pq[i]);
        for (int i = 0; i < hold; i++) push(0, 2'b00, 0, 0, 6'd0, 0, 0, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            chk("timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Single compare process: every cycle outside reset with a model entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("WrPC",        bus.WrPC,        e.wrpc);
            chk("SelA",        bus.SelA,        e.sela);
            chk("SelB",        bus.SelB,        e.selb);
            chk("WrAcc",       bus.WrAcc,       e.wracc);
            chk("Op",          bus.Op,          e.op);
            chk("WrRam",       bus.WrRam,       e.wrram);
            chk("RdRam",       bus.RdRam,       e.rdram);
            chk("operand",     bus.operand,     e.opnd);
            chk("halted",      bus.halted,      e.hlt);
            chk("clk_count",   bus.clk_count,   e.cc);
            chk("instr_count", bus.instr_count, e.ic);
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0812;                         // STO 0x012

        // Reset state
        @(negedge clk);
        chk("rst_WrPC",      bus.WrPC, 0);
        chk("rst_Op",        bus.Op, 0);
        chk("rst_operand",   bus.operand, 0);
        chk("rst_halted",    bus.halted, 0);
        chk("rst_clk_count", bus.clk_count, 0);

        // Reset asserted while STO is in DECODE
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("sto_fetch_WrRam", bus.WrRam, 0);
        @(negedge clk);
        chk("sto_dec_WrRam",   bus.WrRam, 1);
        chk("sto_dec_WrPC",    bus.WrPC, 1);
        chk("sto_dec_operand", bus.operand, 11'h012);
        #1 reset = 1'b1;
        #1;
        chk("sto_abort_WrRam", bus.WrRam, 0);
        chk("sto_abort_WrPC",  bus.WrPC, 0);
        @(posedge clk); #1 reset = 1'b0;
        chk("sto_rel_clk_count", bus.clk_count, 0);
        @(negedge clk);
        chk("sto_refetch_WrRam", bus.WrRam, 0);
        @(negedge clk);
        chk("sto_redecode_WrRam", bus.WrRam, 1);

        // LDI 5; ADDI 3; HLT
        pq = {16'h1805, 16'h2803, 16'h0000};
        run_prog(3);
        chk("p1_instr_count", bus.instr_count, 2);
        chk("p1_clk_count",   bus.clk_count, 6);
        chk("p1_halted",      bus.halted, 1);

        // LD 0x010; SUB 0x011; STO 0x012; HLT
        pq = {16'h1010, 16'h3011, 16'h0812, 16'h0000};
        run_prog(3);
        chk("p2_instr_count", bus.instr_count, 3);
        chk("p2_clk_count",   bus.clk_count, 10);

        // NOP (opcode 11111); HLT, then 100 cycles parked in HALT
        pq = {16'hFFFF, 16'h0000};
        run_prog(100);
        chk("p3_instr_count", bus.instr_count, 1);
        chk("p3_clk_count",   bus.clk_count, 4);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("halt_rst_halted",    bus.halted, 0);
        chk("halt_rst_clk_count", bus.clk_count, 0);

        // Randomized programs
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 25);
            pq.delete();
            for (int i = 0; i < len; i++)
                pq.push_back({5'($urandom_range(1, 31)), 11'($urandom)});
            pq.push_back(16'h0000);
            run_prog($urandom_range(1, 10));
        end

        // Narrow counters saturate
        @(posedge clk); #1 rst4 = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("sat_instr_count", bus4.instr_count, 15);
        chk("sat_clk_count",   bus4.clk_count, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
